// File: rtl/dmem_arbiter.sv
// Arbiter for the single-port data memory. The CPU load/store unit has fixed priority, and a DMA/debug
// port is guaranteed a grant after DMA_MAX_WAIT consecutive lost arbitrations.
module dmem_arbiter #(
  parameter int unsigned DMA_MAX_WAIT = 4,
  parameter int unsigned WAIT_W       = 3,
  parameter logic [31:0] DMA_BASE     = 32'h0000_1000,
  parameter logic [31:0] DMA_LIMIT    = 32'h0000_1FFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_sign_mask,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESP_CPU = 2'd1,
    RESP_DMA = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DMA_MAX_WAIT);

  state_t            state, state_nx;
  logic              owner_we, owner_we_nx;
  logic              dma_err_r, dma_err_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic              dma_in_range, grant_dma, grant_cpu;

  assign dma_in_range = (dma_addr >= DMA_BASE) && (dma_addr <= DMA_LIMIT);
  assign grant_dma    = (state == IDLE) && dma_req && ((wait_cnt == WAIT_MAX) || !cpu_req);
  assign grant_cpu    = (state == IDLE) && cpu_req && !grant_dma;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_we  <= 1'b0;
      dma_err_r <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nx;
      owner_we  <= owner_we_nx;
      dma_err_r <= dma_err_nx;
      wait_cnt  <= wait_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    owner_we_nx    = owner_we;
    dma_err_nx     = dma_err_r;
    wait_nx        = wait_cnt;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_memwrite   = 1'b0;
    mem_memread    = 1'b0;
    mem_sign_mask  = '0;
    cpu_ack        = 1'b0;
    cpu_rdata      = '0;
    dma_ack        = 1'b0;
    dma_rdata      = '0;
    dma_err        = 1'b0;

    case (state)
      IDLE: begin
        if (grant_dma) begin
          state_nx    = RESP_DMA;
          owner_we_nx = dma_we;
          dma_err_nx  = !dma_in_range;
          wait_nx     = '0;
          // An out-of-range DMA access still consumes the grant, but never reaches memory.
          if (dma_in_range) begin
            mem_addr       = dma_addr;
            mem_write_data = dma_wdata;
            mem_sign_mask  = dma_sign_mask;
            mem_memwrite   = dma_we;
            mem_memread    = !dma_we;
          end
        end else if (grant_cpu) begin
          state_nx       = RESP_CPU;
          owner_we_nx    = cpu_we;
          mem_addr       = cpu_addr;
          mem_write_data = cpu_wdata;
          mem_sign_mask  = cpu_sign_mask;
          mem_memwrite   = cpu_we;
          mem_memread    = !cpu_we;
          if (dma_req && (wait_cnt < WAIT_MAX)) begin
            wait_nx = wait_cnt + 1'b1;
          end
        end
      end
      RESP_CPU: begin
        cpu_ack  = 1'b1;
        state_nx = IDLE;
        if (!owner_we) begin
          cpu_rdata = mem_read_data;
        end
      end
      RESP_DMA: begin
        dma_ack  = 1'b1;
        dma_err  = dma_err_r;
        state_nx = IDLE;
        if (!owner_we) begin
          dma_rdata = mem_read_data;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Reset abandons any access in flight; nothing may reach memory or a requester while it is low.
    if (!rst_n) begin
      mem_addr       = '0;
      mem_write_data = '0;
      mem_sign_mask  = '0;
      mem_memwrite   = 1'b0;
      mem_memread    = 1'b0;
      cpu_ack        = 1'b0;
      cpu_rdata      = '0;
      dma_ack        = 1'b0;
      dma_rdata      = '0;
      dma_err        = 1'b0;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a cycle-level transaction model kept in this
// bench. The model tracks the pending response, the starvation count and a small word memory.
module tb_dmem_arbiter;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_sign_mask;
  logic        dma_req, dma_we, dma_ack, dma_err;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_sign_mask;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread;
  logic [3:0]  mem_sign_mask;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DMA_MAX_WAIT(MAXW), .WAIT_W(3), .DMA_BASE(32'h1000), .DMA_LIMIT(32'h1FFF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_sign_mask(cpu_sign_mask), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_sign_mask(dma_sign_mask), .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] tmem [0:255];

  // Model: 0 = nothing pending, 1 = CPU response due, 2 = DMA response due.
  int          m_busy;
  logic        m_we, m_err;
  logic [31:0] m_rval;
  int          m_wait;

  logic        s_rd, s_wr, s_cpu_ack, s_dma_ack, s_dma_err, s_stall;
  logic [31:0] s_addr, s_wd, s_cpu_rdata;
  logic        x_cack, x_dack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return (a >= 32'h1000) && (a <= 32'h1FFF);
  endfunction

  // One clock: compare outputs mid-cycle, then advance memory and model at the edge.
  task automatic step();
    logic [31:0] e_addr, e_wd, e_crd, e_drd;
    logic [3:0]  e_sm;
    logic        e_rd, e_wr, e_cack, e_dack, e_derr, e_stall, g_cpu, g_dma;
    @(negedge clk);
    e_addr = '0; e_wd = '0; e_sm = '0; e_rd = 0; e_wr = 0;
    e_cack = 0; e_dack = 0; e_derr = 0; e_crd = '0; e_drd = '0;
    g_cpu = 0; g_dma = 0;
    if (rst_n) begin
      if (m_busy == 1) begin
        e_cack = 1;
        e_crd  = m_we ? 32'h0 : m_rval;
      end else if (m_busy == 2) begin
        e_dack = 1;
        e_derr = m_err;
        e_drd  = m_we ? 32'h0 : (m_err ? mem_read_data : m_rval);
      end else begin
        g_dma = dma_req && (m_wait >= MAXW || !cpu_req);
        g_cpu = !g_dma && cpu_req;
        if (g_cpu) begin
          e_addr = cpu_addr; e_wd = cpu_wdata; e_sm = cpu_sign_mask;
          e_rd = !cpu_we; e_wr = cpu_we;
        end else if (g_dma && in_range(dma_addr)) begin
          e_addr = dma_addr; e_wd = dma_wdata; e_sm = dma_sign_mask;
          e_rd = !dma_we; e_wr = dma_we;
        end
      end
    end
    e_stall = cpu_req && !e_cack;

    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_write_data, e_wd);
    check("mem_sign_mask", 32'(mem_sign_mask), 32'(e_sm));
    check("mem_memread", 32'(mem_memread), 32'(e_rd));
    check("mem_memwrite", 32'(mem_memwrite), 32'(e_wr));
    check("cpu_ack", 32'(cpu_ack), 32'(e_cack));
    check("cpu_rdata", cpu_rdata, e_crd);
    check("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    check("dma_ack", 32'(dma_ack), 32'(e_dack));
    check("dma_err", 32'(dma_err), 32'(e_derr));
    check("dma_rdata", dma_rdata, e_drd);

    s_rd = mem_memread; s_wr = mem_memwrite; s_addr = mem_addr; s_wd = mem_write_data;
    s_cpu_ack = cpu_ack; s_dma_ack = dma_ack; s_dma_err = dma_err; s_stall = cpu_stall;
    s_cpu_rdata = cpu_rdata;
    x_cack = e_cack; x_dack = e_dack;

    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0;
      m_wait = 0;
    end else if (m_busy != 0) begin
      m_busy = 0;
    end else if (g_dma) begin
      m_busy = 2; m_we = dma_we; m_err = !in_range(dma_addr);
      m_rval = tmem[dma_addr[9:2]];
      m_wait = 0;
    end else if (g_cpu) begin
      m_busy = 1; m_we = cpu_we; m_err = 0;
      m_rval = tmem[cpu_addr[9:2]];
      if (dma_req && m_wait < MAXW) m_wait++;
    end
    if (s_wr) tmem[s_addr[9:2]] = s_wd;
    mem_read_data = s_rd ? tmem[s_addr[9:2]] : $urandom;
    #1;
  endtask

  function automatic logic [31:0] cpu_pick();
    if ($urandom_range(0, 9) == 0) return 32'h2000;
    return 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
  endfunction

  function automatic logic [31:0] dma_pick();
    logic [31:0] edge_addr [6];
    edge_addr = '{32'h0FFF, 32'h1000, 32'h1FFF, 32'h2000, 32'h0000_0000, 32'hFFFF_FFFC};
    if ($urandom_range(0, 3) == 0) return edge_addr[$urandom_range(0, 5)];
    return 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] led_before;
    int cpu_wins, strobes, acks;
    logic dma_seen;

    rst_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_sign_mask = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_sign_mask = '0;
    mem_read_data = '0;
    m_busy = 0; m_we = 0; m_err = 0; m_rval = '0; m_wait = 0;
    for (int i = 0; i < 256; i++) tmem[i] = $urandom;
    a = 32'h1004;
    tmem[a[9:2]] = 32'hDEADBEEF;
    #1;
    step(); step();
    rst_n = 1;

    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1004; cpu_sign_mask = 4'b0010;
    step();
    check("load_issue", 32'(s_rd), 32'd1);
    check("load_stall_T", 32'(s_stall), 32'd1);
    step();
    check("load_ack", 32'(s_cpu_ack), 32'd1);
    check("load_data", s_cpu_rdata, 32'hDEADBEEF);
    check("load_stall_T1", 32'(s_stall), 32'd0);

    cpu_we = 1; cpu_addr = 32'h1008; cpu_wdata = 32'h12345678; cpu_sign_mask = 4'b0111;
    step();
    check("store_issue", 32'(s_wr), 32'd1);
    check("store_addr", s_addr, 32'h1008);
    check("store_wdata", s_wd, 32'h12345678);
    step();
    check("store_ack", 32'(s_cpu_ack), 32'd1);
    check("store_rdata", s_cpu_rdata, 32'h0);

    cpu_we = 0; cpu_addr = 32'h1010;
    dma_req = 1; dma_we = 0; dma_addr = 32'h1100; dma_sign_mask = 4'b0010;
    cpu_wins = 0; dma_seen = 0;
    for (int i = 0; i < 24 && !dma_seen; i++) begin
      step();
      if (s_dma_ack) dma_seen = 1;
      else if (s_cpu_ack) begin
        cpu_wins++;
        cpu_addr = cpu_pick();
      end
    end
    check("contention_cpu_wins", 32'(cpu_wins), 32'(MAXW));
    check("contention_dma_grant", 32'(dma_seen), 32'd1);
    dma_req = 0;
    step(); step();
    cpu_req = 0;
    step();

    a = 32'h2000;
    led_before = tmem[a[9:2]];
    dma_req = 1; dma_we = 1; dma_addr = 32'h2000; dma_wdata = 32'hCAFEF00D;
    step();
    check("oor_no_write", 32'(s_wr), 32'd0);
    check("oor_no_read", 32'(s_rd), 32'd0);
    step();
    check("oor_ack", 32'(s_dma_ack), 32'd1);
    check("oor_err", 32'(s_dma_err), 32'd1);
    check("oor_led_untouched", tmem[a[9:2]], led_before);
    dma_req = 0;

    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1004;
    step();
    check("rst_mid_issue", 32'(s_rd), 32'd1);
    rst_n = 0;
    step();
    check("rst_mid_no_ack", 32'(s_cpu_ack), 32'd0);
    rst_n = 1;
    step();
    check("rst_reissue", 32'(s_rd), 32'd1);
    step();
    check("rst_reissue_ack", 32'(s_cpu_ack), 32'd1);
    check("rst_reissue_data", s_cpu_rdata, 32'hDEADBEEF);
    cpu_req = 0;

    strobes = 0; acks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      strobes += int'(s_rd) + int'(s_wr);
      acks    += int'(s_cpu_ack) + int'(s_dma_ack);
    end
    check("idle_strobes", 32'(strobes), 32'd0);
    check("idle_acks", 32'(acks), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if (!cpu_req || x_cack) begin
        cpu_req = ($urandom_range(0, 99) < 60);
        cpu_we = 1'($urandom); cpu_addr = cpu_pick(); cpu_wdata = $urandom;
        cpu_sign_mask = 4'($urandom);
      end
      if (!dma_req || x_dack) begin
        dma_req = ($urandom_range(0, 99) < 50);
        dma_we = 1'($urandom); dma_addr = dma_pick(); dma_wdata = $urandom;
        dma_sign_mask = 4'($urandom);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
